fadd_wb: RTL and testbench

FADD_WB -- requirements
Module: fadd_wb

---
 rtl/fadd_wb.sv | 152 +++++++++++++++
 tb/tb_fadd_wb.sv | 303 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fadd_wb.sv
// fadd_wb: tracks destination tags of issued fadd ops through a LAT-stage shadow pipeline,
// pairs each tag with the fpu result on its ready pulse, and buffers {tag, data} in an in-order
// writeback FIFO. A credit pool of DEPTH covers ops in flight plus buffered results.
// Optional feature: define FADD_WB_BYPASS_EN to forward a result straight to the writeback port
// when the FIFO is empty.
module fadd_wb #(
    parameter int unsigned LAT   = 3,
    parameter int unsigned DEPTH = 4,
    parameter int unsigned TAG_W = 6
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             issue_valid,
    input  logic [TAG_W-1:0] issue_tag,
    output logic             issue_ok,
    input  logic             fpu_ready,
    input  logic [31:0]      fpu_c,
    output logic             wb_valid,
    output logic [TAG_W-1:0] wb_tag,
    output logic [31:0]      wb_data,
    input  logic             wb_ack,
    output logic             busy,
    output logic             err
);

    localparam int unsigned   CW      = $clog2(DEPTH) + 1;
    localparam int unsigned   PW      = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [PW-1:0] LastPtr = PW'(DEPTH - 1);
    localparam logic [CW-1:0] DepthC  = CW'(DEPTH);

    logic [LAT-1:0]   pipe_valid_q;
    // Marks pipeline slots that held an op when reset hit, so its late ready pulse is ignored.
    logic [LAT-1:0]   ghost_q;
    logic [TAG_W-1:0] pipe_tag_q [LAT];
    logic [TAG_W-1:0] mem_tag_q  [DEPTH];
    logic [31:0]      mem_data_q [DEPTH];
    logic [PW-1:0]    wr_ptr_q, rd_ptr_q;
    logic [CW-1:0]    count_q, count_d;
    logic [CW-1:0]    inflight_q, inflight_d;
    logic             err_q, err_d;

    logic        tail_valid, tail_ghost, accept, capture;
    logic        fifo_pop, fifo_push, push_drop, bypass_take;
    logic [CW:0] used;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == LastPtr) ? '0 : p + PW'(1);
    endfunction

    // Credit check uses registered counters only.
    assign used     = {1'b0, inflight_q} + {1'b0, count_q};
    assign issue_ok = (used < {1'b0, DepthC});
    assign busy     = (inflight_q != '0) | (count_q != '0);
    assign err      = err_q;

    // Next-state for counters and error flag, plus push/pop decisions.
    always_comb begin
        accept     = issue_valid & issue_ok;
        tail_valid = pipe_valid_q[LAT-1];
        tail_ghost = ghost_q[LAT-1];
        capture    = tail_valid & fpu_ready;
        fifo_pop   = (count_q != '0) & wb_ack;
`ifdef FADD_WB_BYPASS_EN
        bypass_take = capture & (count_q == '0) & wb_ack;
`else
        bypass_take = 1'b0;
`endif
        push_drop = capture & ~bypass_take & (count_q == DepthC) & ~fifo_pop;
        fifo_push = capture & ~bypass_take & ~push_drop;

        inflight_d = inflight_q;
        if (accept) begin
            inflight_d = inflight_d + CW'(1);
        end
        // The tail leaves the pipeline every cycle, captured or not, so its credit moves on.
        if (tail_valid) begin
            inflight_d = inflight_d - CW'(1);
        end

        count_d = count_q;
        if (fifo_push && !fifo_pop) begin
            count_d = count_q + CW'(1);
        end else if (!fifo_push && fifo_pop) begin
            count_d = count_q - CW'(1);
        end

        err_d = err_q
              | (issue_valid & ~issue_ok)
              | (fpu_ready & ~tail_valid & ~tail_ghost)
              | (tail_valid & ~fpu_ready)
              | push_drop;
    end

    // Writeback port: FIFO head, or the live result when bypassing an empty FIFO.
    always_comb begin
        wb_valid = (count_q != '0);
        wb_tag   = wb_valid ? mem_tag_q[rd_ptr_q] : '0;
        wb_data  = wb_valid ? mem_data_q[rd_ptr_q] : '0;
`ifdef FADD_WB_BYPASS_EN
        if ((count_q == '0) && capture) begin
            wb_valid = 1'b1;
            wb_tag   = pipe_tag_q[LAT-1];
            wb_data  = fpu_c;
        end
`endif
    end

    // Control state: valid pipeline, counters, pointers and sticky error.
    always_ff @(posedge clk) begin
        if (rst) begin
            pipe_valid_q <= '0;
            ghost_q[0]   <= 1'b0;
            for (int i = 1; i < LAT; i++) begin
                ghost_q[i] <= ghost_q[i-1] | pipe_valid_q[i-1];
            end
            inflight_q <= '0;
            count_q    <= '0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            err_q      <= 1'b0;
        end else begin
            pipe_valid_q[0] <= accept;
            ghost_q[0]      <= 1'b0;
            for (int i = 1; i < LAT; i++) begin
                pipe_valid_q[i] <= pipe_valid_q[i-1];
                ghost_q[i]      <= ghost_q[i-1];
            end
            inflight_q <= inflight_d;
            count_q    <= count_d;
            err_q      <= err_d;
            if (fifo_push) begin
                wr_ptr_q <= ptr_inc(wr_ptr_q);
            end
            if (fifo_pop) begin
                rd_ptr_q <= ptr_inc(rd_ptr_q);
            end
        end
    end

    // Datapath storage: tag shift pipeline and FIFO entries need no reset.
    always_ff @(posedge clk) begin
        pipe_tag_q[0] <= issue_tag;
        for (int i = 1; i < LAT; i++) begin
            pipe_tag_q[i] <= pipe_tag_q[i-1];
        end
        if (!rst && fifo_push) begin
            mem_tag_q[wr_ptr_q]  <= pipe_tag_q[LAT-1];
            mem_data_q[wr_ptr_q] <= fpu_c;
        end
    end

endmodule

// File: tb/tb_fadd_wb.sv
// Testbench for fadd_wb: table of single-op transactions plus hand-written multi-cycle
// sequences; writebacks are checked against a scoreboard queue. Define FADD_WB_BYPASS_EN for
// both files to exercise the bypass build.
module tb_fadd_wb;

    logic        clk;
    logic        rst;
    logic        issue_valid;
    logic [5:0]  issue_tag;
    logic        issue_ok;
    logic        fpu_ready;
    logic [31:0] fpu_c;
    logic        wb_valid;
    logic [5:0]  wb_tag;
    logic [31:0] wb_data;
    logic        wb_ack;
    logic        busy;
    logic        err;

    int n_cmp;
    int n_bad;

    typedef struct {
        logic [5:0]  tag;
        logic [31:0] data;
        logic [5:0]  exp_tag;
        logic [31:0] exp_data;
    } vec_t;

    typedef struct {
        logic [5:0]  tag;
        logic [31:0] data;
    } sb_t;

    vec_t vecs [4];
    sb_t  sb [$];
    sb_t  mon_e;

    fadd_wb #(
        .LAT   (3),
        .DEPTH (4),
        .TAG_W (6)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .issue_valid (issue_valid),
        .issue_tag   (issue_tag),
        .issue_ok    (issue_ok),
        .fpu_ready   (fpu_ready),
        .fpu_c       (fpu_c),
        .wb_valid    (wb_valid),
        .wb_tag      (wb_tag),
        .wb_data     (wb_data),
        .wb_ack      (wb_ack),
        .busy        (busy),
        .err         (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        issue_valid = 1'b0;
        issue_tag   = '0;
        fpu_ready   = 1'b0;
        fpu_c       = '0;
        wb_ack      = 1'b0;
    endtask

    task automatic sb_push(input logic [5:0] tag, input logic [31:0] data);
        sb_t e;
        e.tag  = tag;
        e.data = data;
        sb.push_back(e);
    endtask

    // Scoreboard monitor: every accepted writeback must match the oldest expected result.
    always @(negedge clk) begin
        if (!rst && wb_valid && wb_ack) begin
            if (sb.size() == 0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL sb_unexpected_wb: got tag 0x%0h data 0x%0h, expected none",
                         wb_tag, wb_data);
            end else begin
                mon_e = sb.pop_front();
                check("sb_wb_tag", 64'(wb_tag), 64'(mon_e.tag));
                check("sb_wb_data", 64'(wb_data), 64'(mon_e.data));
            end
        end
    end

    initial begin
        n_cmp = 0;
        n_bad = 0;
        vecs[0] = '{6'd5,  32'h4040_0000, 6'd5,  32'h4040_0000};
        vecs[1] = '{6'd0,  32'h0000_0000, 6'd0,  32'h0000_0000};
        vecs[2] = '{6'd63, 32'hFFFF_FFFF, 6'd63, 32'hFFFF_FFFF};
        vecs[3] = '{6'd42, 32'h3F80_0000, 6'd42, 32'h3F80_0000};
        clear_inputs();
        rst = 1'b1;

        // Reset values, during and after reset.
        tick();
        tick();
        #1;
        check("rst_wb_valid", 64'(wb_valid), 64'd0);
        check("rst_wb_tag", 64'(wb_tag), 64'd0);
        check("rst_wb_data", 64'(wb_data), 64'd0);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_err", 64'(err), 64'd0);
        check("rst_issue_ok", 64'(issue_ok), 64'd1);
        rst = 1'b0;
        tick();
        #1;
        check("post_rst_wb_valid", 64'(wb_valid), 64'd0);
        check("post_rst_issue_ok", 64'(issue_ok), 64'd1);

        // Single-op transactions from the table.
        for (int i = 0; i < 4; i++) begin
            tick();
            clear_inputs();
            issue_valid = 1'b1;
            issue_tag   = vecs[i].tag;
            #1;
            check("single_issue_ok", 64'(issue_ok), 64'd1);
            tick();
            clear_inputs();
            #1;
            check("single_busy_c1", 64'(busy), 64'd1);
            check("single_wb_valid_c1", 64'(wb_valid), 64'd0);
            tick();
            tick();
            fpu_ready = 1'b1;
            fpu_c     = vecs[i].data;
            wb_ack    = 1'b1;
            sb_push(vecs[i].exp_tag, vecs[i].exp_data);
            #1;
`ifdef FADD_WB_BYPASS_EN
            check("byp_wb_valid_c3", 64'(wb_valid), 64'd1);
            check("byp_wb_tag_c3", 64'(wb_tag), 64'(vecs[i].exp_tag));
            check("byp_wb_data_c3", 64'(wb_data), 64'(vecs[i].exp_data));
`else
            check("single_wb_valid_c3", 64'(wb_valid), 64'd0);
`endif
            tick();
            fpu_ready = 1'b0;
            fpu_c     = '0;
            #1;
`ifdef FADD_WB_BYPASS_EN
            check("byp_wb_valid_c4", 64'(wb_valid), 64'd0);
            check("byp_issue_ok_c4", 64'(issue_ok), 64'd1);
`else
            check("single_wb_valid_c4", 64'(wb_valid), 64'd1);
            check("single_wb_tag_c4", 64'(wb_tag), 64'(vecs[i].exp_tag));
            check("single_wb_data_c4", 64'(wb_data), 64'(vecs[i].exp_data));
`endif
            tick();
            clear_inputs();
            #1;
            check("single_busy_c5", 64'(busy), 64'd0);
            check("single_wb_valid_c5", 64'(wb_valid), 64'd0);
            check("single_err_c5", 64'(err), 64'd0);
        end

        // Back-to-back fill, over-issue, one ack, push+pop at count 3, drain.
        for (int c = 0; c < 17; c++) begin
            tick();
            clear_inputs();
            if (c <= 3) begin
                issue_valid = 1'b1;
                issue_tag   = 6'(c + 1);
            end
            if (c >= 3 && c <= 6) begin
                fpu_ready = 1'b1;
                fpu_c     = 32'h100 + 32'(c - 2);
                sb_push(6'(c - 2), 32'h100 + 32'(c - 2));
            end
            if (c == 7) begin
                issue_valid = 1'b1;
                issue_tag   = 6'd33;
            end
            if (c == 8) wb_ack = 1'b1;
            if (c == 9) begin
                issue_valid = 1'b1;
                issue_tag   = 6'd9;
            end
            if (c == 12) begin
                fpu_ready = 1'b1;
                fpu_c     = 32'h900;
                wb_ack    = 1'b1;
                sb_push(6'd9, 32'h900);
            end
            if (c >= 13 && c <= 15) wb_ack = 1'b1;
            #1;
            if (c <= 3) check("b2b_issue_ok_open", 64'(issue_ok), 64'd1);
            if (c >= 4 && c <= 8) check("b2b_issue_ok_full", 64'(issue_ok), 64'd0);
            if (c == 7) begin
                check("b2b_head_valid", 64'(wb_valid), 64'd1);
                check("b2b_head_tag", 64'(wb_tag), 64'd1);
                check("b2b_head_data", 64'(wb_data), 64'h101);
                check("b2b_err_before_over", 64'(err), 64'd0);
            end
            if (c == 8) check("over_err", 64'(err), 64'd1);
            if (c == 9) begin
                check("ack_issue_ok", 64'(issue_ok), 64'd1);
                check("ack_head_tag", 64'(wb_tag), 64'd2);
            end
            if (c == 13) begin
                check("pushpop_issue_ok", 64'(issue_ok), 64'd1);
                check("pushpop_head_tag", 64'(wb_tag), 64'd3);
                check("pushpop_wb_valid", 64'(wb_valid), 64'd1);
            end
            if (c == 16) begin
                check("drain_wb_valid", 64'(wb_valid), 64'd0);
                check("drain_busy", 64'(busy), 64'd0);
                check("err_sticky", 64'(err), 64'd1);
            end
        end

        // Reset mid-flight: late ready pulse for a pre-reset op is ignored.
        tick();
        clear_inputs();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        #1;
        check("rst_clears_err", 64'(err), 64'd0);
        issue_valid = 1'b1;
        issue_tag   = 6'd7;
        tick();
        clear_inputs();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        #1;
        check("midrst_busy_c2", 64'(busy), 64'd0);
        check("midrst_issue_ok_c2", 64'(issue_ok), 64'd1);
        tick();
        fpu_ready = 1'b1;
        fpu_c     = 32'hDEAD_BEEF;
        #1;
        check("midrst_wb_valid_c3", 64'(wb_valid), 64'd0);
        tick();
        clear_inputs();
        #1;
        check("midrst_wb_valid_c4", 64'(wb_valid), 64'd0);
        check("midrst_busy_c4", 64'(busy), 64'd0);
        check("midrst_err_c4", 64'(err), 64'd0);

        // Tail reaches the end without a ready pulse: credit freed, error raised.
        tick();
        issue_valid = 1'b1;
        issue_tag   = 6'd12;
        tick();
        clear_inputs();
        tick();
        tick();
        tick();
        #1;
        check("noready_err", 64'(err), 64'd1);
        check("noready_busy", 64'(busy), 64'd0);
        check("noready_issue_ok", 64'(issue_ok), 64'd1);
        check("noready_wb_valid", 64'(wb_valid), 64'd0);

        // Stray ready pulse with nothing in flight.
        rst = 1'b1;
        tick();
        rst = 1'b0;
        tick();
        tick();
        tick();
        tick();
        fpu_ready = 1'b1;
        fpu_c     = 32'h1234_5678;
        tick();
        clear_inputs();
        #1;
        check("stray_err", 64'(err), 64'd1);
        check("stray_wb_valid", 64'(wb_valid), 64'd0);
        check("stray_busy", 64'(busy), 64'd0);

        tick();
        check("sb_drained", 64'(sb.size()), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
